// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Detects load-use hazards and taken-branch redirects, tracks the
// multi-cycle mult/div unit, and keeps saturating stall/flush counters.
// All pipeline control outputs are combinational, so a hazard seen in a
// cycle is acted upon in that same cycle.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_muldiv,
    input  logic             id_reads_hilo,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The mult/div latency lives in a 4-bit down-counter, hence the 1..15 range.
    localparam logic [3:0]       MD_LAT_V = 4'(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    mdState_t         r_state;
    mdState_t         w_nextState;
    logic [3:0]       r_mdCnt;
    logic [3:0]       w_nextMdCnt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic w_rsMatch;
    logic w_rtMatch;
    logic w_luHaz;
    logic w_mdHaz;
    logic w_stall;
    logic w_mdIssue;

    assign md_busy   = (r_state == MD_BUSY);
    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;

    // Hazard terms; $0 is hardwired to zero so a load targeting it never
    // creates a dependency, and an older taken branch cancels any stall.
    always_comb begin
        w_rsMatch = id_uses_rs && (id_rs == ex_rd);
        w_rtMatch = id_uses_rt && (id_rt == ex_rd);
        w_luHaz   = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
                    && (w_rsMatch || w_rtMatch);
        w_mdHaz   = id_valid && md_busy && (id_is_muldiv || id_reads_hilo);
        w_stall   = (w_luHaz || w_mdHaz) && !ex_branch_taken;
        w_mdIssue = id_valid && id_is_muldiv && !w_stall && !ex_branch_taken;
    end

    // Pipeline control with redirect taking priority over stall.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_stall) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end
    end

    // Mult/div occupancy: issue loads the latency, busy counts down to 1 and
    // then returns to RUN; a flush never cancels an already-issued operation.
    always_comb begin
        w_nextState = r_state;
        w_nextMdCnt = r_mdCnt;
        case (r_state)
            RUN: begin
                if (w_mdIssue) begin
                    w_nextState = MD_BUSY;
                    w_nextMdCnt = MD_LAT_V;
                end
            end
            MD_BUSY: begin
                if (r_mdCnt == 4'd1) begin
                    w_nextState = RUN;
                    w_nextMdCnt = 4'd0;
                end else begin
                    w_nextMdCnt = r_mdCnt - 4'd1;
                end
            end
            default: begin
                w_nextState = RUN;
                w_nextMdCnt = 4'd0;
            end
        endcase
    end

    // Mult/div state register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_mdCnt <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_mdCnt <= w_nextMdCnt;
        end
    end

    // Saturating statistics: stall cycles and redirect cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_stall && (r_stallCnt != CNT_MAX)) begin
                r_stallCnt <= r_stallCnt + CNT_ONE;
            end
            if (ex_branch_taken && (r_flushCnt != CNT_MAX)) begin
                r_flushCnt <= r_flushCnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver issues one stimulus per
// cycle and pushes the reference model's expected response; a monitor
// pops and compares a settled moment after each stimulus is applied.
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic       rstn;
        logic       idValid;
        logic [4:0] idRs;
        logic [4:0] idRt;
        logic       usesRs;
        logic       usesRt;
        logic       isMd;
        logic       readsHilo;
        logic       exValid;
        logic       exMemRead;
        logic [4:0] exRd;
        logic       taken;
    } stim_t;

    typedef struct {
        logic     pcWe;
        logic     ifidWe;
        logic     flush;
        logic     bubble;
        logic     busy;
        int       stallCnt;
        int       flushCnt;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_muldiv;
    logic             id_reads_hilo;
    logic             ex_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   testsFail = 0;

    // Reference model state: remaining busy cycles and the two statistics.
    int   mdRemaining = 0;
    int   modelStalls = 0;
    int   modelFlushes = 0;

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_is_muldiv   (id_is_muldiv),
        .id_reads_hilo  (id_reads_hilo),
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write_en    (pc_write_en),
        .ifid_write_en  (ifid_write_en),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .md_busy        (md_busy),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    // Free-running pipeline clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One field comparison; every call is one counted test.
    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s = '{rstn:1'b1, idValid:1'b0, idRs:5'd0, idRt:5'd0, usesRs:1'b0, usesRt:1'b0,
              isMd:1'b0, readsHilo:1'b0, exValid:1'b0, exMemRead:1'b0, exRd:5'd0, taken:1'b0};
        return s;
    endfunction

    // Drive one cycle of inputs at the falling edge, then let the model
    // predict this cycle's response and advance to the next cycle.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   busy, lu, md, stall, issue;
        @(negedge clk);
        reset           = s.rstn;
        id_valid        = s.idValid;
        id_rs           = s.idRs;
        id_rt           = s.idRt;
        id_uses_rs      = s.usesRs;
        id_uses_rt      = s.usesRt;
        id_is_muldiv    = s.isMd;
        id_reads_hilo   = s.readsHilo;
        ex_valid        = s.exValid;
        ex_mem_read     = s.exMemRead;
        ex_rd           = s.exRd;
        ex_branch_taken = s.taken;
        if (!s.rstn) begin
            mdRemaining  = 0;
            modelStalls  = 0;
            modelFlushes = 0;
        end
        busy  = (mdRemaining > 0);
        lu    = s.idValid && s.exValid && s.exMemRead && (s.exRd != 0) &&
                ((s.usesRs && s.idRs == s.exRd) || (s.usesRt && s.idRt == s.exRd));
        md    = s.idValid && busy && (s.isMd || s.readsHilo);
        stall = (lu || md) && !s.taken;
        issue = s.idValid && s.isMd && !stall && !s.taken;
        e.flush    = s.taken;
        e.bubble   = s.taken || stall;
        e.pcWe     = s.taken || !stall;
        e.ifidWe   = s.taken || !stall;
        e.busy     = busy;
        e.stallCnt = modelStalls;
        e.flushCnt = modelFlushes;
        expQ.push_back(e);
        if (s.rstn) begin
            if (busy) mdRemaining--;
            else if (issue) mdRemaining = MD_LAT;
            if (stall && modelStalls < CNT_MAX) modelStalls++;
            if (s.taken && modelFlushes < CNT_MAX) modelFlushes++;
        end
    endtask

    // Monitor: once outputs have settled after each stimulus, pop the
    // expected response and compare every output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("pc_write_en",   int'(pc_write_en),   int'(e.pcWe));
                checkOutput("ifid_write_en", int'(ifid_write_en), int'(e.ifidWe));
                checkOutput("ifid_flush",    int'(ifid_flush),    int'(e.flush));
                checkOutput("idex_bubble",   int'(idex_bubble),   int'(e.bubble));
                checkOutput("md_busy",       int'(md_busy),       int'(e.busy));
                checkOutput("stall_cnt",     int'(stall_cnt),     e.stallCnt);
                checkOutput("flush_cnt",     int'(flush_cnt),     e.flushCnt);
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        stim_t s;
        stim_t lw8;
        reset = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_is_muldiv = 1'b0; id_reads_hilo = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
        ex_rd = '0; ex_branch_taken = 1'b0;

        s = idleStim(); s.rstn = 1'b0;
        applyStimulus(s);
        applyStimulus(s);
        repeat (2) applyStimulus(idleStim());

        // Load-use on rs, then the bubble clears ex_valid.
        lw8 = idleStim();
        lw8.idValid = 1'b1; lw8.idRs = 5'd8; lw8.usesRs = 1'b1;
        lw8.exValid = 1'b1; lw8.exMemRead = 1'b1; lw8.exRd = 5'd8;
        applyStimulus(lw8);
        s = lw8; s.exValid = 1'b0;
        applyStimulus(s);

        // Both operands match: still a single stall cycle.
        s = lw8; s.idRt = 5'd8; s.usesRt = 1'b1;
        applyStimulus(s);
        s.exValid = 1'b0;
        applyStimulus(s);

        // Load to $0 never stalls.
        s = lw8; s.idRs = 5'd0; s.exRd = 5'd0;
        applyStimulus(s);

        // Mult issue then mflo stalls through the busy window.
        s = idleStim(); s.idValid = 1'b1; s.isMd = 1'b1;
        applyStimulus(s);
        s = idleStim(); s.idValid = 1'b1; s.readsHilo = 1'b1;
        repeat (5) applyStimulus(s);

        // Load-use together with a taken branch: flush wins.
        s = lw8; s.taken = 1'b1;
        applyStimulus(s);

        // Flush in the issue cycle suppresses the mult.
        s = idleStim(); s.idValid = 1'b1; s.isMd = 1'b1; s.taken = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Reset while the counter holds 2 aborts the operation.
        s = idleStim(); s.idValid = 1'b1; s.isMd = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        s = idleStim(); s.rstn = 1'b0;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Continuous stall past the counter limit.
        repeat ((1 << CNT_W) + 3) applyStimulus(lw8);
        s = idleStim(); s.rstn = 1'b0;
        applyStimulus(s);

        // Randomized traffic with a small register pool to raise hit rates.
        for (int i = 0; i < 3000; i++) begin
            s.rstn      = ($urandom_range(0, 199) != 0);
            s.idValid   = ($urandom_range(0, 9) != 0);
            s.idRs      = 5'($urandom_range(0, 3));
            s.idRt      = 5'($urandom_range(0, 3));
            s.usesRs    = 1'($urandom);
            s.usesRt    = 1'($urandom);
            s.isMd      = ($urandom_range(0, 4) == 0);
            s.readsHilo = ($urandom_range(0, 4) == 0);
            s.exValid   = 1'($urandom);
            s.exMemRead = 1'($urandom);
            s.exRd      = 5'($urandom_range(0, 3));
            s.taken     = ($urandom_range(0, 6) == 0);
            applyStimulus(s);
        end

        repeat (3) @(negedge clk);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the PC write enable and the IF/ID pipeline-register controls: hold, and a flush that zeroes the register's enable bit. It also drives the ID/EX bubble insertion.
It detects load-use hazards and taken-branch redirects, and tracks the multi-cycle multiply/divide unit with an internal busy counter. It keeps saturating stall and flush statistics counters.

Parameters:
MD_LAT, 4, cycles the mult/div unit is busy after issue (valid range 1..15)
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  pipeline clock, rising-edge
reset  input  1  asynchronous, active-low reset
id_valid  input  1  the IF/ID register holds a valid instruction (its enable bit)
id_rs  input  5  rs field of the ID instruction
id_rt  input  5  rt field of the ID instruction
id_uses_rs  input  1  the ID instruction reads rs
id_uses_rt  input  1  the ID instruction reads rt
id_is_muldiv  input  1  the ID instruction is mult/multu/div/divu
id_reads_hilo  input  1  the ID instruction is mfhi/mflo/mthi/mtlo
ex_valid  input  1  the ID/EX stage holds a valid instruction
ex_mem_read  input  1  the EX instruction is a load
ex_rd  input  5  destination register of the EX instruction
ex_branch_taken  input  1  a branch or jump resolved as taken in EX this cycle
pc_write_en  output  1  the PC register may update
ifid_write_en  output  1  the IF/ID register may capture new values
ifid_flush  output  1  force next_enable=0 into IF/ID
idex_bubble  output  1  force the ID/EX valid bit to 0
md_busy  output  1  the mult/div unit is occupied
stall_cnt  output  CNT_W  saturating count of stall cycles
flush_cnt  output  CNT_W  saturating count of flush events

Behaviour:
- Reset (reset=0, asynchronous):
  - md_cnt=0, state=RUN, stall_cnt=0, flush_cnt=0.
  - All outputs follow from those values: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0, md_busy=0.
- Combinational hazard terms:
  - lu_haz = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - md_haz = id_valid & md_busy & (id_is_muldiv | id_reads_hilo).
  - stall = (lu_haz | md_haz) & ~ex_branch_taken.
- Output priority:
  - When ex_branch_taken=1, flush wins: ifid_flush=1, idex_bubble=1, pc_write_en=1, ifid_write_en=1.
  - Else when stall=1: pc_write_en=0, ifid_write_en=0, idex_bubble=1, ifid_flush=0.
  - Else: pc_write_en=1, ifid_write_en=1, idex_bubble=0, ifid_flush=0.
- All outputs except the counters are combinational from the inputs and the registered state. There is zero-cycle latency from hazard to control.
- Mult/div FSM, states RUN and MD_BUSY; md_busy = (state==MD_BUSY):
  - RUN -> MD_BUSY when id_valid & id_is_muldiv & ~stall & ~ex_branch_taken; md_cnt loads MD_LAT.
  - MD_BUSY: md_cnt decrements each cycle. When md_cnt==1, the next state is RUN and md_cnt becomes 0.
  - A muldiv in ID while in MD_BUSY stalls and does not reload. It issues the cycle after the return to RUN.
  - A branch flush does not cancel an in-flight mult/div, because that instruction is older than the branch.
  - A flush in the same cycle as a would-be issue suppresses the issue.
- Counters:
  - stall_cnt increments by 1 on each cycle with stall=1.
  - flush_cnt increments by 1 on each cycle with ex_branch_taken=1.
  - Both saturate at all-ones and never wrap.
- Register $0 never causes a load-use hazard.
- Both uses_rs and uses_rt matching the same ex_rd produces a single stall cycle.
- A load-use stall lasts exactly one cycle: the bubble clears ex_valid on the next cycle.
- Reset asserted mid-operation aborts MD_BUSY immediately and clears both counters.

Test Plan:
- Release reset, idle inputs -> pc_write_en=1, ifid_write_en=1, idex_bubble=0, md_busy=0, stall_cnt=0, flush_cnt=0.
- EX lw rd=8; ID add with rs=8, uses_rs=1 -> exactly 1 cycle with pc_write_en=0, ifid_write_en=0, idex_bubble=1. stall_cnt goes 0->1. The next cycle (ex_valid=0) is back to normal.
- EX lw rd=0; ID reads rs=0 -> no stall, stall_cnt stays 0.
- MD_LAT=4: issue mult; next cycle ID mflo -> md_busy=1 for 4 cycles and mflo stalls until md_busy=0. It proceeds in the cycle md_busy first reads 0. stall_cnt=4 once mflo has been stalled for the 4 busy cycles.
- Load-use hazard and ex_branch_taken=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write_en=1, stall_cnt unchanged, flush_cnt +1.
- Assert reset while md_cnt=2 -> md_busy=0 immediately, counters 0. Force stall for 2^CNT_W+3 cycles -> stall_cnt holds at 2^CNT_W-1.
